// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DFLT = 32'h8000_0000;
  localparam logic [31:0] INST_STEP         = 32'd4;

  // Instruction addresses are word aligned; low two bits are ignored.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Output slot to decode plus a one-entry hold buffer.
// The hold buffer catches a response that arrives while decode is stalled.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,    // redirect: drop slot and hold contents
  input  logic        stall_i,    // decode not consuming this cycle
  input  logic        ld_slot_i,  // load incoming response into the slot
  input  logic        ld_hold_i,  // park incoming response in the hold buffer
  input  logic        mv_hold_i,  // move hold buffer into the slot
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        slot_free_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q;
  logic [31:0] pc_q, inst_q;
  logic        hold_valid_q;
  logic [31:0] hold_pc_q, hold_inst_q;

  // Slot can take new data if empty or being consumed this cycle.
  assign slot_free_o = !valid_q || !stall_i;

  // Output slot register: flush beats everything, then fresh load, then refill from hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (ld_slot_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end else if (mv_hold_i && hold_valid_q) begin
      valid_q <= 1'b1;
      pc_q    <= hold_pc_q;
      inst_q  <= hold_inst_q;
    end else if (!stall_i) begin
      valid_q <= 1'b0;
    end
  end

  // Hold buffer register: filled when the slot is occupied, emptied into the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_inst_q  <= '0;
    end else if (flush_i) begin
      hold_valid_q <= 1'b0;
    end else if (ld_hold_i) begin
      hold_valid_q <= 1'b1;
      hold_pc_q    <= pc_i;
      hold_inst_q  <= inst_i;
    end else if (mv_hold_i) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the fetch PC, runs one I-cache read at a
// time and applies decode redirects, discarding any response they make stale.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        id_stall,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ack,
  input  logic [31:0] ic_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] fetch_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_pc;
  logic         slot_free;
  logic         ld_slot, ld_hold, mv_hold, flush;

  assign redir_pc = align_word(redirect_addr);

  // State and fetch PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, next PC and slot controls; redirect outranks sequential fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ld_slot = 1'b0;
    ld_hold = 1'b0;
    mv_hold = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = WAIT;
        if (redirect_valid) begin
          pc_d  = redir_pc;
          flush = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          // A same-cycle ack closes the request; otherwise wait out its ack.
          pc_d    = redir_pc;
          flush   = 1'b1;
          state_d = ic_ack ? WAIT : DRAIN;
        end else if (ic_ack) begin
          pc_d = pc_q + INST_STEP;
          if (slot_free) begin
            ld_slot = 1'b1;
          end else begin
            ld_hold = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          flush   = 1'b1;
          state_d = WAIT;
        end else if (slot_free) begin
          mv_hold = 1'b1;
          state_d = WAIT;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          flush   = 1'b1;
          state_d = ic_ack ? WAIT : DRAIN;
        end else if (ic_ack) begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ic_req   = (state_q == WAIT);
  assign ic_addr  = pc_q;
  assign fetch_pc = pc_q;

  fetch_skid u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .stall_i     (id_stall),
    .ld_slot_i   (ld_slot),
    .ld_hold_i   (ld_hold),
    .mv_hold_i   (mv_hold),
    .pc_i        (pc_q),
    .inst_i      (ic_rdata),
    .slot_free_o (slot_free),
    .valid_o     (if_valid),
    .pc_o        (if_pc),
    .inst_o      (if_inst)
  );

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios, then random cache latency, stalls
// and redirects checked against an in-order instruction-stream model.
module tb_fetch_seq;
  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk, rst;
  logic        redirect_valid, id_stall, ic_ack;
  logic [31:0] redirect_addr, ic_rdata;
  logic        ic_req, if_valid;
  logic [31:0] ic_addr, if_pc, if_inst, fetch_pc;

  int checks = 0;
  int errors = 0;

  fetch_seq dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .id_stall(id_stall),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .fetch_pc(fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a function of address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, return at the following negedge.
  task automatic tick(input logic ack, input logic [31:0] data, input logic stall,
                      input logic redir, input logic [31:0] raddr);
    ic_ack = ack; ic_rdata = data; id_stall = stall;
    redirect_valid = redir; redirect_addr = raddr;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_pc, req_addr, r;
    logic        outst, ack_now, stall, redir;
    int          cnt, consumed;

    rst = 1'b1; redirect_valid = 0; redirect_addr = 0; id_stall = 0;
    ic_ack = 0; ic_rdata = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_req", ic_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_fpc", fetch_pc, RV);

    // Sequential fetch with an ack every cycle
    rst = 1'b0;
    @(negedge clk);
    chk("seq_req0", ic_req, 1);
    chk("seq_addr0", ic_addr, RV);
    tick(1, mem(RV), 0, 0, 0);
    chk("seq_addr1", ic_addr, RV + 4);
    chk("seq_v0", if_valid, 1);
    chk("seq_pc0", if_pc, RV);
    chk("seq_inst0", if_inst, mem(RV));
    tick(1, mem(RV + 4), 0, 0, 0);
    chk("seq_addr2", ic_addr, RV + 8);
    chk("seq_pc1", if_pc, RV + 4);

    // Stall: next response parks in the hold buffer
    tick(1, mem(RV + 8), 1, 0, 0);
    chk("hold_req", ic_req, 0);
    chk("hold_pc", if_pc, RV + 4);
    chk("hold_fpc", fetch_pc, RV + 12);
    tick(0, 0, 1, 0, 0);
    chk("hold_req2", ic_req, 0);
    tick(0, 0, 1, 0, 0);
    chk("hold_pc2", if_pc, RV + 4);
    tick(0, 0, 0, 0, 0);
    chk("unhold_pc", if_pc, RV + 8);
    chk("unhold_inst", if_inst, mem(RV + 8));
    chk("unhold_req", ic_req, 1);
    chk("unhold_addr", ic_addr, RV + 12);
    tick(1, mem(RV + 12), 0, 0, 0);
    chk("post_pc", if_pc, RV + 12);

    // Redirect with a request pending, stale ack two cycles later
    tick(0, 0, 0, 1, RV + 32'h100);
    chk("drain_req", ic_req, 0);
    chk("drain_valid", if_valid, 0);
    chk("drain_fpc", fetch_pc, RV + 32'h100);
    tick(0, 0, 0, 0, 0);
    chk("drain_req2", ic_req, 0);
    tick(1, mem(RV + 16), 0, 0, 0);
    chk("drain_valid2", if_valid, 0);
    chk("drain_exit_req", ic_req, 1);
    chk("drain_exit_addr", ic_addr, RV + 32'h100);

    // Redirect coinciding with an ack: no drain
    tick(1, mem(RV + 32'h100), 0, 1, RV + 32'h200);
    chk("rack_req", ic_req, 1);
    chk("rack_addr", ic_addr, RV + 32'h200);
    chk("rack_valid", if_valid, 0);

    // PC wrap, then misaligned redirect target
    tick(1, mem(RV + 32'h200), 0, 1, 32'hFFFF_FFFC);
    chk("wrap_addr", ic_addr, 32'hFFFF_FFFC);
    tick(1, mem(32'hFFFF_FFFC), 0, 0, 0);
    chk("wrap_fpc", fetch_pc, 32'h0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    tick(0, 0, 0, 1, 32'h8000_0103);
    chk("align_fpc", fetch_pc, RV + 32'h100);
    tick(1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("align_addr", ic_addr, RV + 32'h100);
    chk("align_valid", if_valid, 0);

    // Async reset while in HOLD with a valid slot
    tick(1, mem(RV + 32'h100), 0, 0, 0);
    tick(1, mem(RV + 32'h104), 1, 0, 0);
    chk("pre_rst_req", ic_req, 0);
    chk("pre_rst_valid", if_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", if_valid, 0);
    chk("arst_pc", if_pc, 0);
    chk("arst_inst", if_inst, 0);
    chk("arst_fpc", fetch_pc, RV);
    chk("arst_req", ic_req, 0);
    ic_ack = 0; id_stall = 0; redirect_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_addr", ic_addr, RV);

    // Random phase: cache with 0..2 cycle latency, random stalls and redirects
    exp_pc = RV; outst = 0; ack_now = 0; cnt = 0; consumed = 0; req_addr = 0;
    for (int i = 0; i < 4000; i++) begin
      if (ack_now) outst = 0;
      if (ic_req && outst) chk("addr_stable", ic_addr, req_addr);
      if (ic_req && !outst) begin
        outst = 1; req_addr = ic_addr; cnt = $urandom_range(0, 2);
      end
      ack_now = outst && (cnt == 0);
      if (outst && cnt > 0) cnt--;
      stall = ($urandom_range(0, 2) == 0);
      redir = ($urandom_range(0, 19) == 0);
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
      // Decode sees the program stream in order; a redirect restarts it.
      if (if_valid && !stall && !redir) begin
        chk("rnd_pc", if_pc, exp_pc);
        chk("rnd_inst", if_inst, mem(exp_pc));
        exp_pc = exp_pc + 4;
        consumed++;
      end
      if (redir) exp_pc = {r[31:2], 2'b00};
      tick(ack_now, ack_now ? mem(req_addr) : $urandom, stall, redir, r);
    end
    chk("rnd_progress", 32'(consumed > 500), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer sitting between the program counter and the instruction cache. Owns the fetch PC, issues one I-cache read at a time with a req/ack handshake, and delivers fetched instructions to decode through a registered output slot plus a one-entry hold buffer. Applies decode-stage redirects (taken branch, jump, jr) with priority over sequential fetch, and discards any in-flight cache response that a redirect makes stale.

## Interface
- RESET_VECTOR, 32'h8000_0000, fetch PC after reset
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  single-cycle pulse from decode: fetch redirect
- redirect_addr  in  32  redirect target; bits [1:0] forced to 00 internally
- id_stall  in  1  decode cannot consume the output slot this cycle
- ic_req  out  1  I-cache read request
- ic_addr  out  32  I-cache read address, equals fetch PC
- ic_ack  in  1  single-cycle response pulse; ic_rdata valid in the same cycle
- ic_rdata  in  32  instruction word
- if_valid  out  1  output slot holds an instruction
- if_pc  out  32  address of the instruction in the output slot
- if_inst  out  32  instruction in the output slot
- fetch_pc  out  32  current fetch PC

## Operation
- No branch-delay-slot logic here: decode raises redirect_valid only after accepting the delay-slot instruction; a redirect kills everything younger.
- Slot consumed when if_valid && !id_stall. Slot is free when !if_valid or when it is being consumed.
- States: IDLE, WAIT, HOLD, DRAIN.
- IDLE: entered on reset; unconditionally goes to WAIT next cycle. ic_req=0.
- WAIT: ic_req=1, ic_addr=fetch_pc. On ic_ack without redirect: if slot free, load slot (if_valid=1, if_pc=fetch_pc, if_inst=ic_rdata), fetch_pc+=4, stay WAIT; else write hold buffer, fetch_pc+=4, go HOLD.
- HOLD: ic_req=0. When slot free, move hold buffer into slot, go WAIT.
- DRAIN: ic_req=0, waiting for the ack of an abandoned request; that ack's data is dropped, then go WAIT.
- Redirect (highest priority, any state except IDLE): fetch_pc←{redirect_addr[31:2],2'b00}, if_valid←0, hold buffer dropped. Next state: DRAIN if in WAIT with no ic_ack this cycle; WAIT if in WAIT with ic_ack this cycle (data dropped), in HOLD, or DRAIN with ic_ack this cycle; remain DRAIN if in DRAIN without ic_ack.
- Redirect while id_stall=1: redirect still wins; slot cleared.
- Redirect in IDLE: fetch_pc updated, IDLE→WAIT as normal.
- fetch_pc+4 wraps modulo 2^32.

## Timing
- Reset values: fetch_pc=RESET_VECTOR, ic_req=0, if_valid=0, if_pc=0, if_inst=0, hold buffer empty, state IDLE.
- First ic_req in the first cycle after rst deasserts (IDLE lasts one cycle).
- ic_addr stable while ic_req=1 and no ack; changes only on the edge that samples ic_ack or a redirect.
- Only one request outstanding; ic_req stays high across back-to-back acks, giving 1 instruction/cycle peak throughput.
- ack→if_valid latency: 1 cycle (slot registered on the ack edge).
- Redirect→first ic_req with new address: next cycle if no request is outstanding; otherwise the cycle after the stale ic_ack.
- rst mid-operation: all state abandoned immediately; the I-cache shares rst, so no stale ack is expected after reset.

## Structure
- Shared package fetch_pkg: state enum (IDLE, WAIT, HOLD, DRAIN), RESET_VECTOR default, INST_STEP=4.
- One sub-module: fetch_skid — output slot plus one-entry hold buffer with flush input; the FSM and PC register stay in fetch_seq.

## Test plan
- Reset release, cache acks every cycle, id_stall=0 -> ic_addr 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; if_pc follows one cycle later with if_valid=1.
- id_stall=1 held for 3 cycles with acks arriving -> second instruction goes to the hold buffer, ic_req drops, no instruction lost or duplicated after stall release.
- Redirect to 8000_0100 while request to 8000_0010 pending, ack 2 cycles later -> state DRAIN, stale data never reaches if_valid, next ic_addr=8000_0100.
- Redirect in the same cycle as ic_ack -> ack data dropped, next cycle ic_req=1 with ic_addr=redirect target, no DRAIN.
- fetch_pc=FFFF_FFFC, ack -> fetch_pc wraps to 0000_0000; redirect_addr=8000_0103 -> ic_addr=8000_0100.
- rst asserted in HOLD with if_valid=1 -> all outputs return to reset values asynchronously; fetch restarts at 8000_0000.
